forwarding_hazard_unit: RTL
===========================

# forwarding_hazard_unit

Generates the 2-bit select codes for the two EX-stage 3:1 operand multiplexers of the 32-bit pipelined datapath. It also detects load-use hazards and raises the pipeline stall/bubble controls. The unit keeps its own shadow copy of destination-register and control bits for the ID/EX, EX/MEM and MEM/WB stages. Selects are computed while an instruction is in ID and registered, so they are stable for the whole EX cycle of that instruction.

## Interface
- NREG, 32: number of architectural registers; register index width is clog2(NREG) = 5.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  source register A of the instruction in ID.
- id_rt  in  5  source register B of the instruction in ID.
- id_rd  in  5  destination register of the instruction in ID.
- id_regwrite  in  1  instruction in ID writes id_rd.
- id_memread  in  1  instruction in ID is a load.
- id_valid  in  1  ID holds a real instruction; 0 means bubble.
- ext_stall  in  1  global freeze, e.g. memory wait.
- flush  in  1  taken branch; kills the instruction in ID.
- sel_a  out  2  select for the operand-A mux, registered.
- sel_b  out  2  select for the operand-B mux, registered.
- stall  out  1  hold PC and IF/ID this cycle, combinational.
- bubble  out  1  ID/EX receives a NOP this cycle, combinational.

## Operation
- Select encoding: 00 = register-file value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value. Code 11 is never driven.
- Shadow stages: each stage holds {valid, rd, regwrite, memread}, in the order ID/EX → EX/MEM → MEM/WB. On each non-frozen edge every shadow stage shifts one step.
- Forward check for src ∈ {id_rs, id_rt}, applied when the ID instruction is valid:
  - If src ≠ 0 and src matches a valid ID/EX entry with regwrite set and memread clear → select 01.
  - Otherwise, if src matches a valid EX/MEM entry with regwrite set → select 10.
  - Otherwise → select 00.
  - The younger producer (ID/EX) has priority over EX/MEM.
- Register 0 is never forwarded and never causes a stall.
- Load-use hazard: the ID/EX entry is valid, has memread and regwrite set, its rd is nonzero, and rd equals id_rs or id_rt. Response:
  - stall = 1 and bubble = 1.
  - ID/EX shadow loads valid = 0.
  - sel_a and sel_b register 00.
  - On the next cycle the load sits in EX/MEM, so the dependent instruction gets select 10.
- Stall FSM states:
  - RUN → LU_STALL when a load-use hazard is detected.
  - LU_STALL → RUN unconditionally, unless ext_stall is high, in which case it stays in LU_STALL.
  - stall is asserted while the hazard condition holds; it never lasts more than 1 cycle per load when forwarding is enabled.
- flush: the ID/EX shadow loads valid = 0 and the selects register 00. flush overrides a load-use stall in the same cycle: stall = 0, bubble = 1.
- ext_stall: all shadow registers, sel_a, sel_b and the FSM hold their values. stall and bubble are driven 0. ext_stall has priority over flush and over hazards.

## Timing
- Reset values: sel_a = sel_b = 00, stall = 0, bubble = 0, all shadow valid bits = 0, FSM = RUN.
- Select latency: 1 cycle. Selects computed from ID inputs in cycle n appear on sel_a/sel_b in cycle n+1, the instruction's EX cycle.
- stall and bubble are combinational from the ID inputs and the registered shadows in the same cycle.
- Reset asserted mid-stall clears all state on the next edge. stall is 0 from the first cycle after that edge.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - sel_a and sel_b are constant 00.
  - Any RAW match against a valid, regwrite-set ID/EX entry stalls; this covers loads and ALU producers.
  - Any RAW match against a valid, regwrite-set EX/MEM entry also stalls.
  - A dependency on the immediately preceding instruction therefore stalls 2 cycles.
  - The register file writes before it reads, so no WB-stage check is needed.
  - The FSM gains state STALL2, which precedes LU_STALL.

## Structure
- Shared package fwd_pkg:
  - SEL_REG = 2'b00, SEL_EXMEM = 2'b01, SEL_MEMWB = 2'b10.
  - REG_ZERO = 5'd0.
  - The shadow-stage struct type.
  - The FSM state enum.
- Sub-module fwd_compare: combinational, instanced twice (for rs and rt). Takes src plus the two shadow entries and returns a 2-bit select and a hazard flag.

## Test plan
- add r3 followed by sub using r3 as rs → cycle n+1: sel_a = 01, sel_b = 00, no stall.
- add r3, unrelated op, then or using r3 as rt → sel_b = 10.
- lw r5 followed by add using r5 as rs → stall = 1 and bubble = 1 for one cycle, selects 00 that cycle; next cycle sel_a = 10.
- Instruction writing r0, followed by a reader of r0 → selects 00, no stall. Same check applies for a load to r0.
- lw r5 hazard with flush in the same cycle → stall = 0, bubble = 1. Then ext_stall held for 3 cycles → outputs frozen, stall = 0.
- FORWARDING_EN undefined, back-to-back add r3 / sub r3 → stall for 2 cycles, selects always 00. Reset asserted during the second stall cycle → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard logic.
// Honours the FORWARDING_EN build macro through the modules that import it.
package fwd_pkg;

  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = $clog2(NREG);

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL2   = 2'd1,
    LU_STALL = 2'd2
  } state_t;

  // True when the stage entry will write src; r0 never counts as a producer.
  function automatic logic writes_src(input logic [REG_W-1:0] src, input stage_t e);
    return e.valid && e.regwrite && (src != REG_ZERO) && (e.rd == src);
  endfunction

endpackage

// File: rtl/fwd_compare.sv
// Per-source dependency check against the ID/EX and EX/MEM shadow entries.
// FORWARDING_EN selects forwarding selects vs. stall-on-any-RAW behaviour.
module fwd_compare
  import fwd_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  stage_t           idex,
  input  stage_t           exmem,
  output logic [1:0]       sel,
  output logic             hazard
);

  logic unused_memread;
  assign unused_memread = idex.memread ^ exmem.memread;

  always_comb begin
    sel    = SEL_REG;
    hazard = 1'b0;
`ifdef FORWARDING_EN
    // A load one ahead cannot be forwarded in time; it must stall instead.
    if (writes_src(src, idex)) begin
      if (idex.memread) hazard = 1'b1;
      else              sel    = SEL_EXMEM;
    end else if (writes_src(src, exmem)) begin
      sel = SEL_MEMWB;
    end
`else
    hazard = writes_src(src, idex) || writes_src(src, exmem);
`endif
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand-mux select generation and hazard stall/bubble control for the EX stage.
// Build macro FORWARDING_EN enables forwarding; otherwise every RAW dependency stalls.
module forwarding_hazard_unit
  import fwd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_valid,
  input  logic             ext_stall,
  input  logic             flush,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic             bubble
);

  stage_t idex_q, exmem_q, memwb_q;
  stage_t idex_d;
  state_t state_q, state_d;

  logic [1:0] sel_a_d, sel_b_d;
  logic       haz_a, haz_b;
  logic       hazard, kill, issue_ok;

  fwd_compare u_cmp_a (
    .src    (id_rs),
    .idex   (idex_q),
    .exmem  (exmem_q),
    .sel    (sel_a_d),
    .hazard (haz_a)
  );

  fwd_compare u_cmp_b (
    .src    (id_rt),
    .idex   (idex_q),
    .exmem  (exmem_q),
    .sel    (sel_b_d),
    .hazard (haz_b)
  );

  assign hazard   = id_valid & (haz_a | haz_b);
  assign kill     = flush | hazard;
  assign issue_ok = id_valid & ~kill;

  // Freeze masks everything; flush wins over a stall but still injects a NOP.
  assign stall  = ~ext_stall & ~flush & hazard;
  assign bubble = ~ext_stall & kill;

  logic unused_memwb;
  assign unused_memwb = ^memwb_q;

  always_comb begin
    idex_d          = '0;
    idex_d.valid    = issue_ok;
    idex_d.rd       = id_rd;
    idex_d.regwrite = id_regwrite;
    idex_d.memread  = id_memread;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      sel_a   <= SEL_REG;
      sel_b   <= SEL_REG;
    end else if (!ext_stall) begin
      idex_q  <= idex_d;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
      sel_a   <= issue_ok ? sel_a_d : SEL_REG;
      sel_b   <= issue_ok ? sel_b_d : SEL_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

`ifndef FORWARDING_EN
  logic idex_dep;
  assign idex_dep = writes_src(id_rs, idex_q) | writes_src(id_rt, idex_q);
`endif

  always_comb begin
    state_d = state_q;
    if (!ext_stall) begin
      unique case (state_q)
        RUN: begin
          if (stall) begin
`ifdef FORWARDING_EN
            state_d = LU_STALL;
`else
            // A producer still in ID/EX costs two stall cycles, one in EX/MEM costs one.
            state_d = idex_dep ? STALL2 : LU_STALL;
`endif
          end
        end
        STALL2:   state_d = flush ? RUN : LU_STALL;
        LU_STALL: state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

endmodule
